dma_wr_packer: RTL and testbench

Host-write-side counterpart of the DMA read/unpack path. Fetches 32-bit words from the memory controller DMA port, packs 16 consecutive words into one 512-bit cache line and pushes it into the DMA write FIFO under full back-pressure. Sits between memory_controller (DMA port) and the dma write channel in the AFU; its done pulse marks the end of the result transfer.

---
 rtl/dma_pkg.sv | 23 ++
 rtl/dma_wr_packer_line_packer.sv | 30 +++
 rtl/dma_wr_packer.sv | 130 +++++++++++++
 tb/tb_dma_wr_packer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA write-side cache-line packer.
package dma_pkg;

  localparam int unsigned CL_WIDTH       = 512;
  localparam int unsigned WORD_SIZE      = 32;
  localparam int unsigned WORDS_PER_LINE = CL_WIDTH / WORD_SIZE;
  localparam int unsigned WORD_IDX_W     = $clog2(WORDS_PER_LINE);

  typedef logic [WORD_SIZE-1:0]                      word_t;
  typedef logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0]  cl_t;
  typedef logic [WORD_IDX_W-1:0]                     word_idx_t;

  localparam word_idx_t LAST_WORD_IDX = word_idx_t'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_FIN
  } pack_state_e;

endpackage

// File: rtl/dma_wr_packer_line_packer.sv
// 16 x 32-bit slot register assembling one cache line; word N occupies
// bits [32N+31:32N]. Contents persist until overwritten or cleared.
module line_packer
  import dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [WORD_IDX_W-1:0] slot_i,
  input  logic [WORD_SIZE-1:0]  word_i,
  output logic [CL_WIDTH-1:0]   line_o
);

  cl_t line_q;

  // Slot write register; clear takes priority over a slot write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (clr_i) begin
      line_q <= '0;
    end else if (wr_i) begin
      line_q[slot_i] <= word_i;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/dma_wr_packer.sv
// Fetches 32-bit words from the memory controller DMA port one at a time,
// packs 16 of them into a 512-bit cache line and pushes each line into the
// DMA write FIFO, honouring its full flag. done pulses when all lines are out.
module dma_wr_packer
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned SIZE_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [SIZE_WIDTH-1:0] num_lines,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [WORD_SIZE-1:0]  mem_rd_data,
  input  logic                  dma_full,
  output logic                  dma_wr_en,
  output logic [CL_WIDTH-1:0]   dma_wr_data,
  output logic                  busy,
  output logic                  done
);

  pack_state_e           state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SIZE_WIDTH-1:0] line_target_q;
  logic [SIZE_WIDTH-1:0] line_cnt_q;
  logic [SIZE_WIDTH-1:0] line_cnt_d;
  word_idx_t             word_idx_q;
  logic                  mem_en_q;
  logic                  busy_q;
  logic                  done_q;

  assign line_cnt_d = line_cnt_q + 1'b1;

  // Transfer sequencer: one outstanding read per word, one push per line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      line_target_q <= '0;
      line_cnt_q    <= '0;
      word_idx_q    <= '0;
      mem_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      mem_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q        <= base_addr;
            line_target_q <= num_lines;
            line_cnt_q    <= '0;
            word_idx_q    <= '0;
            if (num_lines == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= S_REQ;
              mem_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_valid) begin
            addr_q <= addr_q + 1'b1;
            if (word_idx_q == LAST_WORD_IDX) begin
              word_idx_q <= '0;
              state_q    <= S_PUSH;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
              state_q    <= S_REQ;
              mem_en_q   <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          if (!dma_full) begin
            line_cnt_q <= line_cnt_d;
            if (line_cnt_d == line_target_q) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= S_REQ;
              mem_en_q <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  line_packer u_line_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  ((state_q == S_IDLE) && start),
    .wr_i   ((state_q == S_WAIT) && mem_valid),
    .slot_i (word_idx_q),
    .word_i (mem_rd_data),
    .line_o (dma_wr_data)
  );

  // The push strobe is decoded from the current state and dma_full rather
  // than registered, so it can never be high in a cycle where dma_full is.
  assign dma_wr_en = (state_q == S_PUSH) && !dma_full;

  assign mem_en    = mem_en_q;
  assign mem_wr_en = 1'b0;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dma_wr_packer.sv
// Self-checking bench for dma_wr_packer: randomized memory latency, spurious
// valids and FIFO back-pressure against a line-level reference model.
module tb_dma_wr_packer;

  localparam int AW  = 28;
  localparam int SW  = 17;
  localparam int CLW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] num_lines;
  logic          mem_en;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [31:0]   mem_rd_data;
  logic          dma_full;
  logic          dma_wr_en;
  logic [CLW-1:0] dma_wr_data;
  logic          busy;
  logic          done;

  dma_wr_packer #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .num_lines   (num_lines),
    .mem_en      (mem_en),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_rd_data (mem_rd_data),
    .dma_full    (dma_full),
    .dma_wr_en   (dma_wr_en),
    .dma_wr_data (dma_wr_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Memory contents model and responder controls
  int unsigned data_mode;
  logic [31:0] salt;
  int unsigned lat_max;
  bit          spur_en;
  bit          full_rand;

  // Observation logs
  logic [CLW-1:0] got_lines[$];
  int unsigned    push_cyc[$];
  int unsigned    done_cyc[$];
  logic [AW-1:0]  req_addr[$];
  int unsigned    full_viol;
  int unsigned    wr_viol;

  task automatic check_eq(input string tag, input logic [CLW-1:0] got, input logic [CLW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (data_mode == 0) return {4'h0, a};
    return ({4'h0, a} * 32'h9E3779B1) ^ salt;
  endfunction

  // Line k of a transfer holds the 16 words at base+16k .. base+16k+15.
  function automatic logic [CLW-1:0] exp_line(input logic [AW-1:0] base, input int unsigned k);
    logic [CLW-1:0] l;
    logic [AW-1:0]  a;
    l = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      a = base + AW'(16 * k + j);
      l[j*32 +: 32] = mem_word(a);
    end
    return l;
  endfunction

  // Memory responder: answers each request after 0..lat_max cycles; may
  // raise junk valids in cycles where the packer is not waiting for data.
  initial begin
    logic [AW-1:0] ra;
    int unsigned   lat;
    mem_valid   = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        ra  = mem_addr;
        lat = (lat_max == 0) ? 0 : $urandom_range(0, lat_max);
        #1;
        mem_valid = 1'b0;
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        mem_valid   = 1'b1;
        mem_rd_data = mem_word(ra);
      end else begin
        #1;
        mem_valid   = spur_en && ($urandom_range(0, 1) == 1);
        mem_rd_data = $urandom;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (dma_wr_en) begin
        got_lines.push_back(dma_wr_data);
        push_cyc.push_back(cyc);
        if (dma_full) full_viol++;
      end
      if (done) done_cyc.push_back(cyc);
      if (mem_en) req_addr.push_back(mem_addr);
      if (mem_wr_en) wr_viol++;
    end
  end

  task automatic clear_logs();
    got_lines.delete();
    push_cyc.delete();
    done_cyc.delete();
    req_addr.delete();
    full_viol = 0;
    wr_viol   = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [SW-1:0] n, output int unsigned s);
    @(posedge clk);
    #1;
    base_addr = b;
    num_lines = n;
    start     = 1'b1;
    s         = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    num_lines = SW'($urandom);
  endtask

  // Waits (bounded) for done; optionally pulses start at a fixed offset.
  task automatic wait_done(input int unsigned s, input int unsigned fin_at,
                           input int unsigned restart_at, input string tag);
    int unsigned g;
    g = 0;
    while (done_cyc.size() == 0 && g < 4000) begin
      @(posedge clk);
      #1;
      g++;
      start = (fin_at != 0 && cyc == s + fin_at) || (restart_at != 0 && cyc == s + restart_at);
      if (start) begin
        base_addr = AW'($urandom);
        num_lines = SW'($urandom_range(1, 5));
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, " finished"}, CLW'(g < 4000), CLW'(1));
  endtask

  task automatic verify_xfer(input string tag, input logic [AW-1:0] base, input int unsigned n);
    int unsigned errs;
    check_eq({tag, " pushes"}, CLW'(got_lines.size()), CLW'(n));
    for (int unsigned k = 0; k < got_lines.size() && k < n; k++)
      check_eq($sformatf("%s line%0d", tag, k), got_lines[k], exp_line(base, k));
    errs = 0;
    for (int unsigned i = 0; i < req_addr.size(); i++)
      if (req_addr[i] !== base + AW'(i)) errs++;
    check_eq({tag, " reqcnt"}, CLW'(req_addr.size()), CLW'(16 * n));
    check_eq({tag, " reqaddr"}, CLW'(errs), CLW'(0));
    check_eq({tag, " done"}, CLW'(done_cyc.size()), CLW'(1));
    check_eq({tag, " fullviol"}, CLW'(full_viol + wr_viol), CLW'(0));
  endtask

  initial begin
    int unsigned    s;
    int unsigned    rel;
    int unsigned    errs;
    int unsigned    g;
    int unsigned    n;
    int unsigned    rs;
    logic [AW-1:0]  b;
    logic [CLW-1:0] l;

    rst_n = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0; dma_full = 1'b0;
    data_mode = 0; salt = '0; lat_max = 0; spur_en = 1'b0; full_rand = 1'b0;
    full_viol = 0; wr_viol = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset ctrl", CLW'({mem_en, mem_wr_en, dma_wr_en, busy, done, mem_addr}), '0);
    check_eq("reset line", dma_wr_data, '0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single line, data = address, start pulsed during the done cycle
    clear_logs();
    data_mode = 0;
    pulse_start(28'h100, 1, s);
    check_eq("single busy", CLW'(busy), CLW'(1));
    wait_done(s, 34, 0, "single");
    verify_xfer("single", 28'h100, 1);
    l = (got_lines.size() > 0) ? got_lines[0] : '0;
    check_eq("single w0", CLW'(l[31:0]), CLW'(32'h100));
    check_eq("single w15", CLW'(l[511:480]), CLW'(32'h10F));
    check_eq("single push lat", CLW'((push_cyc.size() > 0) ? push_cyc[0] - s : 0), CLW'(33));
    check_eq("single done lat", CLW'((done_cyc.size() > 0) ? done_cyc[0] - s : 0), CLW'(34));
    check_eq("single idle", CLW'({busy, done, mem_en}), CLW'(0));

    // Zero length
    clear_logs();
    pulse_start(AW'($urandom), 0, s);
    wait_done(s, 0, 0, "zero");
    check_eq("zero done lat", CLW'((done_cyc.size() > 0) ? done_cyc[0] - s : 0), CLW'(1));
    check_eq("zero reqs", CLW'(req_addr.size()), CLW'(0));
    check_eq("zero pushes", CLW'(got_lines.size()), CLW'(0));

    // Back-pressure on the first line
    clear_logs();
    data_mode = 1; salt = $urandom; b = AW'($urandom);
    dma_full = 1'b1;
    pulse_start(b, 2, s);
    while (cyc < s + 33) begin
      @(posedge clk);
      #1;
    end
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (dma_wr_en !== 1'b0 || dma_wr_data !== exp_line(b, 0)) errs++;
      @(posedge clk);
      #1;
    end
    check_eq("bp stable", CLW'(errs), CLW'(0));
    check_eq("bp held", CLW'(got_lines.size()), CLW'(0));
    dma_full = 1'b0;
    rel = cyc;
    wait_done(s, 0, 0, "bp");
    check_eq("bp release", CLW'((push_cyc.size() > 0) ? push_cyc[0] : 0), CLW'(rel));
    check_eq("bp line gap", CLW'((push_cyc.size() > 1) ? push_cyc[1] - push_cyc[0] : 0), CLW'(33));
    verify_xfer("bp", b, 2);

    // Address wrap
    clear_logs();
    salt = $urandom;
    pulse_start(28'hFFFFFF8, 1, s);
    wait_done(s, 0, 0, "wrap");
    verify_xfer("wrap", 28'hFFFFFF8, 1);
    check_eq("wrap addr8", CLW'((req_addr.size() > 8) ? req_addr[8] : 28'hFFFFFFF), CLW'(0));

    // Reset during the wait for word 7
    clear_logs();
    salt = $urandom;
    pulse_start(AW'($urandom), 1, s);
    g = 0;
    while (req_addr.size() < 8 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_eq("rst reached", CLW'(g < 200), CLW'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst ctrl", CLW'({mem_en, mem_wr_en, dma_wr_en, busy, done, mem_addr}), '0);
    check_eq("rst line", dma_wr_data, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    clear_logs();
    b = AW'($urandom);
    pulse_start(b, 1, s);
    wait_done(s, 0, 0, "post rst");
    verify_xfer("post rst", b, 1);

    // Randomized: variable latency, spurious valids, random full, restarts
    lat_max = 5;
    spur_en = 1'b1;
    full_rand = 1'b1;
    fork
      begin
        while (full_rand) begin
          @(posedge clk);
          #1;
          if (full_rand) dma_full = ($urandom_range(0, 3) == 0);
        end
      end
    join_none
    for (int unsigned it = 0; it < 8; it++) begin
      clear_logs();
      salt = $urandom;
      n  = $urandom_range(1, 3);
      b  = ($urandom_range(0, 2) == 0) ? 28'hFFFFFF0 + AW'($urandom_range(0, 15)) : AW'($urandom);
      rs = ($urandom_range(0, 1) == 1) ? 5 : 0;
      pulse_start(b, SW'(n), s);
      wait_done(s, 0, rs, $sformatf("rand%0d", it));
      verify_xfer($sformatf("rand%0d", it), b, n);
    end
    full_rand = 1'b0;
    repeat (2) @(posedge clk);
    dma_full = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
